// File: rtl/ysyx_22040000_mem_pkg.sv
// Shared types and legal parameter ranges for the handshake memory.
package ysyx_22040000_mem_pkg;

  localparam int LATENCY_MIN    = 1;
  localparam int LATENCY_MAX    = 4;
  localparam int RESP_DEPTH_MIN = 1;
  localparam int RESP_DEPTH_MAX = 8;

  // Widest data path the response struct can carry; narrower builds use the
  // low DWIDTH bits and leave the rest at zero.
  localparam int DWIDTH_MAX = 128;

  typedef struct packed {
    logic [DWIDTH_MAX-1:0] rdata;
    logic                  we;
    logic                  err;
  } resp_t;

  function automatic bit in_range(int value, int lo, int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/ysyx_22040000_resp_fifo.sv
// Response queue: circular buffer of resp_t entries with push/pop and
// full/empty flags. The head entry is presented combinationally and stays
// stable until it is popped.
module ysyx_22040000_resp_fifo
  import ysyx_22040000_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  resp_t push_item,
  input  logic  pop,
  output resp_t head,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  resp_t            slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; cleared on reset, dropping any entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents only matter where the pointers say so.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_item;
  end

endmodule

// File: rtl/ysyx_22040000_hs_mem.sv
// Valid/ready word memory with byte-strobed writes, a fixed accept-to-response
// latency and a bounded queue of outstanding responses.
// Optional feature: define YSYX_22040000_HS_MEM_BOUND_CHECK_EN to add the
// DEPTH parameter; addresses at or above DEPTH then suppress writes, return
// zero data and flag resp_err.
module ysyx_22040000_hs_mem
  import ysyx_22040000_mem_pkg::*;
#(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = 32,
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 2
`ifdef YSYX_22040000_HS_MEM_BOUND_CHECK_EN
  ,
  parameter int DEPTH      = 2 ** AWIDTH
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DWIDTH-1:0]   resp_rdata,
  output logic                resp_we,
  output logic                resp_err
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RESP_DEPTH);

  if (!in_range(LATENCY, LATENCY_MIN, LATENCY_MAX)) begin : g_bad_latency
    $error("ysyx_22040000_hs_mem: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
  end
  if (!in_range(RESP_DEPTH, RESP_DEPTH_MIN, RESP_DEPTH_MAX)) begin : g_bad_depth
    $error("ysyx_22040000_hs_mem: RESP_DEPTH %0d outside %0d..%0d", RESP_DEPTH, RESP_DEPTH_MIN, RESP_DEPTH_MAX);
  end
  if ((DWIDTH % 8) != 0 || !in_range(DWIDTH, 8, DWIDTH_MAX)) begin : g_bad_dwidth
    $error("ysyx_22040000_hs_mem: DWIDTH %0d must be a multiple of 8 in 8..%0d", DWIDTH, DWIDTH_MAX);
  end

  logic [DWIDTH-1:0] mem [2**AWIDTH] = '{default: '0};

  logic             accept;
  logic             resp_hs;
  logic             addr_ok;
  logic [CNT_W-1:0] outstanding;
  resp_t            new_item;
  logic             push;
  resp_t            push_item;
  resp_t            head;
  logic             fifo_empty;
  logic             fifo_full_unused;

`ifdef YSYX_22040000_HS_MEM_BOUND_CHECK_EN
  if (!in_range(DEPTH, 1, 2 ** AWIDTH)) begin : g_bad_bound
    $error("ysyx_22040000_hs_mem: DEPTH %0d outside 1..%0d", DEPTH, 2 ** AWIDTH);
  end
  localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH + 1)'(DEPTH);
  assign addr_ok = ({1'b0, req_addr} < DEPTH_LIM);
`else
  assign addr_ok = 1'b1;
`endif

  // req_ready depends only on the registered outstanding count (and reset),
  // so resp_ready never reaches it combinationally.
  assign req_ready  = !rst && (outstanding < CNT_LIMIT);
  assign accept     = req_valid && req_ready;
  assign resp_valid = !rst && !fifo_empty;
  assign resp_hs    = resp_valid && resp_ready;
  assign resp_rdata = resp_valid ? head.rdata[DWIDTH-1:0] : '0;
  assign resp_we    = resp_valid && head.we;
  assign resp_err   = resp_valid && head.err;

  if (DWIDTH < DWIDTH_MAX) begin : g_rdata_hi
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^head.rdata[DWIDTH_MAX-1:DWIDTH];
  end

  // Byte-masked write at the accepting edge; memory is never touched by reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && addr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (req_wstrb[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Response snapshot taken at the accepting edge, so later writes cannot leak in.
  always_comb begin
    new_item     = '0;
    new_item.we  = req_we;
    new_item.err = !addr_ok;
    if (!req_we && addr_ok) new_item.rdata[DWIDTH-1:0] = mem[req_addr];
  end

  // Outstanding-request counter: accepted but not yet handed back.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, resp_hs})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign push      = accept;
    assign push_item = new_item;
  end else begin : g_pipe
    // LATENCY-1 delay stages ahead of the queue; the queue adds the last cycle.
    localparam int STAGES = LATENCY - 1;
    logic [STAGES-1:0] stage_v;
    resp_t             stage_item [STAGES];

    // Stage valid bits, cleared on reset so in-flight responses are dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_v <= '0;
      end else begin
        stage_v[0] <= accept;
        for (int s = 1; s < STAGES; s++) stage_v[s] <= stage_v[s-1];
      end
    end

    // Stage payload shifts every cycle; only entries with a set valid bit count.
    always_ff @(posedge clk) begin
      stage_item[0] <= new_item;
      for (int s = 1; s < STAGES; s++) stage_item[s] <= stage_item[s-1];
    end

    assign push      = stage_v[STAGES-1];
    assign push_item = stage_item[STAGES-1];
  end

  // The outstanding limit keeps the queue from ever overflowing.
  ysyx_22040000_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_item (push_item),
    .pop       (resp_hs),
    .head      (head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ysyx_22040000_hs_mem.sv
// Self-checking bench for ysyx_22040000_hs_mem (LATENCY=3, RESP_DEPTH=2).
// A queue-based reference model predicts req_ready, resp_valid and payload
// every cycle; directed steps cover byte masks, latency, backpressure,
// ordering and reset, followed by a randomized phase.
module tb_ysyx_22040000_hs_mem;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int RD  = 2;
`ifdef YSYX_22040000_HS_MEM_BOUND_CHECK_EN
  localparam int DEPTH = 512;
`else
  localparam int DEPTH = 1 << AW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_we;
  logic          resp_err;

  ysyx_22040000_hs_mem #(
    .AWIDTH     (AW),
    .DWIDTH     (DW),
    .LATENCY    (LAT),
    .RESP_DEPTH (RD)
`ifdef YSYX_22040000_HS_MEM_BOUND_CHECK_EN
    ,
    .DEPTH      (DEPTH)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_we    (resp_we),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          we;
    logic          err;
    int            due;
  } exp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          we;
    logic          err;
  } obs_t;

  exp_t          exp_q[$];
  obs_t          obs_q[$];
  logic [DW-1:0] ref_mem [1 << AW];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  bit            last_acc;
  logic          obs_valid;
  logic          obs_ready;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock period: compare DUT to model at the falling edge, then advance
  // the model across the rising edge.
  task automatic cycle();
    bit   exp_ready;
    bit   exp_valid;
    bit   acc;
    bit   hs;
    exp_t e;
    obs_t o;
    @(negedge clk);
    exp_ready = !rst && (exp_q.size() < RD);
    exp_valid = !rst && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    chk("req_ready", req_ready, exp_ready);
    chk("resp_valid", resp_valid, exp_valid);
    if (exp_valid) begin
      chk("resp_rdata", resp_rdata, exp_q[0].rdata);
      chk("resp_we", resp_we, exp_q[0].we);
      chk("resp_err", resp_err, exp_q[0].err);
    end else if (rst) begin
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_we", resp_we, 0);
      chk("rst_err", resp_err, 0);
    end
    obs_valid = resp_valid;
    obs_ready = req_ready;
    if (resp_valid && resp_ready) begin
      o.rdata = resp_rdata;
      o.we    = resp_we;
      o.err   = resp_err;
      obs_q.push_back(o);
    end
    hs  = exp_valid && resp_ready;
    acc = req_valid && exp_ready;
    last_acc = acc;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (hs) void'(exp_q.pop_front());
      if (acc) begin
        e.we    = req_we;
        e.err   = (int'(req_addr) >= DEPTH);
        e.rdata = '0;
        e.due   = cyc + LAT;
        if (!e.err) begin
          if (req_we) begin
            for (int b = 0; b < 4; b++)
              if (req_wstrb[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          end else begin
            e.rdata = ref_mem[req_addr];
          end
        end
        exp_q.push_back(e);
      end
    end
    #1;
    cyc++;
  endtask

  task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s, output int acc_cyc);
    int c;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    acc_cyc   = -1;
    for (int k = 0; k < 50; k++) begin
      c = cyc;
      cycle();
      if (last_acc) begin
        acc_cyc = c;
        break;
      end
    end
    req_valid = 1'b0;
    chk("send_accepted", acc_cyc >= 0, 1);
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int n;
    int first;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

    // Reset behaviour and first cycle after release.
    repeat (3) cycle();
    chk("rst_valid_low", obs_valid, 0);
    chk("rst_ready_low", obs_ready, 0);
    rst = 1'b0;
    cycle();
    chk("ready_after_reset", obs_ready, 1);

    // Byte-masked write then read-back.
    resp_ready = 1'b1;
    obs_q.delete();
    send(1'b1, 10'd5, 32'hAABBCCDD, 4'hF, a);
    send(1'b1, 10'd5, 32'h11223344, 4'h5, a);
    send(1'b0, 10'd5, 32'h0, 4'h0, a);
    drain();
    chk("mask_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("mask_rdata", obs_q[2].rdata, 32'hAA22CC44);
      chk("mask_we", obs_q[2].we, 0);
      chk("mask_wr_rdata", obs_q[0].rdata, 0);
    end

    // Accept-to-response latency with an empty queue.
    send(1'b0, 10'd5, 32'h0, 4'h0, a);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_valid) begin
        first = cyc - 1;
        break;
      end
    end
    chk("latency", first - a, LAT);
    drain();

    // Backpressure: two reads fit, the third waits until responses drain.
    send(1'b1, 10'd10, 32'h1000000A, 4'hF, a);
    send(1'b1, 10'd11, 32'h1000000B, 4'hF, a);
    send(1'b1, 10'd12, 32'h1000000C, 4'hF, a);
    drain();
    obs_q.delete();
    resp_ready = 1'b0;
    n = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd10;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (last_acc) begin
        n++;
        req_addr = AW'(10 + n);
        if (n == 3) req_valid = 1'b0;
      end
    end
    chk("bp_accepted", n, 2);
    chk("bp_ready_low", obs_ready, 0);
    resp_ready = 1'b1;
    for (int k = 0; k < 20 && n < 3; k++) begin
      cycle();
      if (last_acc) begin
        n++;
        req_valid = 1'b0;
      end
    end
    chk("bp_third_accepted", n, 3);
    drain();
    chk("bp_resp_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("bp_order0", obs_q[0].rdata, 32'h1000000A);
      chk("bp_order1", obs_q[1].rdata, 32'h1000000B);
      chk("bp_order2", obs_q[2].rdata, 32'h1000000C);
    end

    // Read followed by write to the same word under backpressure.
    send(1'b1, 10'd7, 32'h1, 4'hF, a);
    drain();
    obs_q.delete();
    resp_ready = 1'b0;
    send(1'b0, 10'd7, 32'h0, 4'h0, a);
    send(1'b1, 10'd7, 32'h2, 4'hF, a);
    repeat (4) cycle();
    drain();
    send(1'b0, 10'd7, 32'h0, 4'h0, a);
    drain();
    chk("rw_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("rw_read_data", obs_q[0].rdata, 32'h1);
      chk("rw_read_we", obs_q[0].we, 0);
      chk("rw_write_data", obs_q[1].rdata, 32'h0);
      chk("rw_write_we", obs_q[1].we, 1);
      chk("rw_readback", obs_q[2].rdata, 32'h2);
    end

    // Reset pulse with two reads outstanding.
    resp_ready = 1'b0;
    send(1'b0, 10'd5, 32'h0, 4'h0, a);
    send(1'b0, 10'd7, 32'h0, 4'h0, a);
    repeat (4) cycle();
    chk("pre_rst_valid", obs_valid, 1);
    rst = 1'b1;
    cycle();
    chk("midrst_valid", obs_valid, 0);
    rst = 1'b0;
    cycle();
    chk("postrst_ready", obs_ready, 1);
    chk("postrst_valid", obs_valid, 0);
    resp_ready = 1'b1;
    obs_q.delete();
    repeat (10) cycle();
    chk("no_stale_resp", obs_q.size(), 0);

`ifdef YSYX_22040000_HS_MEM_BOUND_CHECK_EN
    // Out-of-range access.
    obs_q.delete();
    send(1'b1, 10'd600, 32'hDEADBEEF, 4'hF, a);
    send(1'b0, 10'd600, 32'h0, 4'h0, a);
    drain();
    chk("oob_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("oob_wr_err", obs_q[0].err, 1);
      chk("oob_rd_err", obs_q[1].err, 1);
      chk("oob_rd_data", obs_q[1].rdata, 0);
    end
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = $urandom_range(0, 1) == 1;
      req_addr   = AW'($urandom_range(0, 15));
`ifdef YSYX_22040000_HS_MEM_BOUND_CHECK_EN
      if ($urandom_range(0, 7) == 0) req_addr = AW'($urandom_range(500, 700));
`endif
      req_wdata  = $urandom;
      req_wstrb  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    req_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040000_hs_mem.md
YSYX_22040000_HS_MEM -- requirements
Module: ysyx_22040000_hs_mem

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, word-address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter LATENCY, default 1, accept-to-response cycles; legal 1..4.
REQ-004 SHALL have parameter RESP_DEPTH, default 2, maximum outstanding responses; legal 1..8.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports req_valid (in, 1) and req_ready (out, 1), request handshake.
REQ-008 SHALL have ports req_we (in, 1), req_addr (in, AWIDTH), req_wdata (in, DWIDTH) and req_wstrb (in, DWIDTH/8), request payload.
REQ-009 SHALL have ports resp_valid (out, 1) and resp_ready (in, 1), response handshake.
REQ-010 SHALL have ports resp_rdata (out, DWIDTH), resp_we (out, 1) and resp_err (out, 1), response payload.

Function
REQ-011 SHALL accept a request on any rising edge where req_valid and req_ready are both high.
REQ-012 SHALL hold 2**AWIDTH words, zero-initialised at simulation start.
REQ-013 SHALL, on an accepted write, update byte i of mem[req_addr] only where req_wstrb[i]=1, at the accepting edge.
REQ-014 SHALL, on an accepted read, sample mem[req_addr] at the accepting edge; later writes do not alter that response.
REQ-015 SHALL return exactly one response per accepted request, in acceptance order.
REQ-016 SHALL set resp_we to the request's req_we; write responses carry resp_rdata=0.
REQ-017 SHALL, for acceptance in cycle N with an empty response queue, first raise resp_valid in cycle N+LATENCY.
REQ-018 SHALL hold resp_valid and the response payload stable until resp_valid and resp_ready are both high.
REQ-019 SHALL track outstanding requests (accepted, not yet responded) in a counter of width clog2(RESP_DEPTH+1).
REQ-020 SHALL update the counter per edge: +1 on accept only, -1 on response handshake only, unchanged on both or neither.
REQ-021 SHALL drive req_ready = (counter < RESP_DEPTH) from registered state only, with no combinational path from resp_ready.
REQ-022 SHALL allow back-to-back acceptance every cycle while resp_ready is held high and RESP_DEPTH >= LATENCY+1.
REQ-023 SHALL never lose or duplicate a response when resp_ready is low for any number of cycles.

Reset
REQ-024 SHALL, while rst is high, force req_ready=0, resp_valid=0, resp_rdata=0, resp_we=0, resp_err=0.
REQ-025 SHALL clear the pipeline valid bits, response queue and counter on reset; in-flight responses are dropped.
REQ-026 SHALL NOT alter memory contents on reset; a write accepted at the edge before rst rises stays committed.
REQ-027 SHALL assert req_ready in the first cycle after rst falls.

Configuration
REQ-028 SHALL compile address bound checking in only when YSYX_22040000_HS_MEM_BOUND_CHECK_EN is defined.
REQ-029 SHALL, with the macro, add parameter DEPTH (default 2**AWIDTH). A request with req_addr >= DEPTH suppresses the write, returns resp_rdata=0 and sets resp_err=1.
REQ-030 SHALL, without the macro, tie resp_err to 0 and use every address.

Structure
REQ-031 SHALL place the response struct typedef {rdata, we, err} and the LATENCY/RESP_DEPTH legal-range constants in package ysyx_22040000_mem_pkg.
REQ-032 SHALL implement the response queue as sub-module ysyx_22040000_resp_fifo (depth RESP_DEPTH, push/pop, full/empty).
REQ-033 SHALL stop elaboration with an error on illegal LATENCY, RESP_DEPTH or DWIDTH.

Verification
REQ-034 Byte-masked write: write 0xAABBCCDD to addr 5 with strb 0xF, then 0x11223344 with strb 0x5, then read addr 5 -> rdata 0xAA22CC44, resp_we=0.
REQ-035 Latency: LATENCY=3, read accepted in cycle 10, resp_ready=1 -> resp_valid first high in cycle 13.
REQ-036 Backpressure: RESP_DEPTH=2, resp_ready=0, 3 reads offered -> 2 accepted, then req_ready=0. Raise resp_ready -> both responses delivered in order, third accepted.
REQ-037 Read-then-write ordering: read addr 7 (holding 0x1), then write 0x2 to addr 7 the next cycle, resp_ready=0 -> the read response is 0x1 and the write response is rdata 0.
REQ-038 Reset mid-flight: two reads outstanding, rst pulsed 1 cycle -> resp_valid=0 during and after reset, with no stale response afterwards. req_ready=1 the cycle after rst falls.
REQ-039 Bound check (macro on, DEPTH=512): write to addr 600 -> resp_err=1 and memory unchanged. Read addr 600 -> rdata 0, err=1.
